// File: rtl/coherence_bus_controller_pkg.sv
// Shared types for the coherence bus controller.
//   word_t      : 32-bit bus word
//   ramstate_t  : RAM port handshake state
//   cc_state_t  : controller FSM state encoding, with IDLE..UPGRADE constants
package coherence_bus_controller_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef logic [2:0] cc_state_t;

    localparam cc_state_t IDLE    = 3'd0;
    localparam cc_state_t SNOOP   = 3'd1;
    localparam cc_state_t C2C     = 3'd2;
    localparam cc_state_t RAM_RD  = 3'd3;
    localparam cc_state_t RAM_WR  = 3'd4;
    localparam cc_state_t IFETCH  = 3'd5;
    localparam cc_state_t UPGRADE = 3'd6;

endpackage

// File: rtl/coherence_bus_controller_rr_arbiter_2.sv
// Two-way round-robin arbiter.
//   clk, rst   : clock, asynchronous active-high reset (pointer -> requester 0)
//   req[1:0]   : request vector
//   advance    : a granted transaction has completed; flip the pointer
//   gnt_valid  : some request is present
//   gnt_idx    : winning requester (pointer side first)
module rr_arbiter_2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    logic ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (advance) begin
            ptr <= ~ptr;
        end
    end

    always_comb begin
        gnt_valid = |req;
        if (req[ptr]) begin
            gnt_idx = ptr;
        end else begin
            gnt_idx = ~ptr;
        end
    end

endmodule

// File: rtl/coherence_bus_controller.sv
// Shared RAM port arbiter and MSI snoop controller for two CPUs.
//   CLK, RST                       : clock, asynchronous active-high reset
//   iREN, iaddr / iwait, iload     : icache request and response
//   dREN, dWEN, daddr, dstore      : dcache request
//   ccwrite, cctrans               : dcache coherence intent
//   dwait, dload                   : dcache response
//   ccwait, ccinv, ccsnoopaddr     : snoop hold / invalidate to the other cache
//   ramaddr, ramstore, ramREN/WEN  : RAM request
//   ramload, ramstate              : RAM response
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | arbitrate; dcache beats icache, round-robin within each
// SNOOP   | one cycle probing the other dcache for a modified copy
// C2C     | snooped cache supplies data and writes it back to RAM
// RAM_RD  | dcache read from RAM, snooped cache held
// RAM_WR  | dcache eviction write-back
// IFETCH  | icache read from RAM
// UPGRADE | one-cycle S->M upgrade, invalidate the other copy
module coherence_bus_controller
    import coherence_bus_controller_pkg::*;
#(
    parameter int CPUS = 2
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [CPUS-1:0]        iREN,
    input  logic [CPUS-1:0]        dREN,
    input  logic [CPUS-1:0]        dWEN,
    input  logic [CPUS-1:0][31:0]  iaddr,
    input  logic [CPUS-1:0][31:0]  daddr,
    input  logic [CPUS-1:0][31:0]  dstore,
    input  logic [CPUS-1:0]        ccwrite,
    input  logic [CPUS-1:0]        cctrans,
    input  logic [31:0]            ramload,
    input  ramstate_t              ramstate,
    output logic [CPUS-1:0]        iwait,
    output logic [CPUS-1:0]        dwait,
    output logic [CPUS-1:0][31:0]  iload,
    output logic [CPUS-1:0][31:0]  dload,
    output logic [31:0]            ramaddr,
    output logic [31:0]            ramstore,
    output logic                   ramREN,
    output logic                   ramWEN,
    output logic [CPUS-1:0]        ccwait,
    output logic [CPUS-1:0]        ccinv,
    output logic [CPUS-1:0][31:0]  ccsnoopaddr
);

    if (CPUS != 2) begin : g_cpus_check
        $error("coherence_bus_controller supports exactly 2 CPUs");
    end

    cc_state_t     state, state_nxt;
    logic          req_q, req_nxt;
    logic          ig_q, ig_nxt;
    logic          inv_q, inv_nxt;
    logic          snp;
    logic          ram_done;
    logic [CPUS-1:0] dreq;
    logic          d_gv, d_gi, i_gv, i_gi;
    logic          d_adv, i_adv;

    assign snp      = ~req_q;
    // ERROR is deliberately not a completion: the access is retried as if BUSY.
    assign ram_done = (ramstate == ACCESS);

    // A dcache only competes when it has something the FSM can act on:
    // a read, an eviction write-back, or a pure S->M upgrade. dWEN with
    // cctrans is a snoop response, not a request.
    always_comb begin
        dreq = '0;
        for (int c = 0; c < CPUS; c++) begin
            dreq[c] = dREN[c]
                    | (dWEN[c] & ~cctrans[c])
                    | (cctrans[c] & ccwrite[c] & ~dREN[c] & ~dWEN[c]);
        end
    end

    rr_arbiter_2 u_d_arb (
        .clk       (CLK),
        .rst       (RST),
        .req       (dreq),
        .advance   (d_adv),
        .gnt_valid (d_gv),
        .gnt_idx   (d_gi)
    );

    rr_arbiter_2 u_i_arb (
        .clk       (CLK),
        .rst       (RST),
        .req       (iREN),
        .advance   (i_adv),
        .gnt_valid (i_gv),
        .gnt_idx   (i_gi)
    );

    always_comb begin
        state_nxt = state;
        req_nxt   = req_q;
        ig_nxt    = ig_q;
        inv_nxt   = inv_q;
        d_adv     = 1'b0;
        i_adv     = 1'b0;
        case (state)
            IDLE: begin
                if (d_gv) begin
                    req_nxt = d_gi;
                    if (dREN[d_gi]) begin
                        state_nxt = SNOOP;
                    end else if (dWEN[d_gi]) begin
                        state_nxt = RAM_WR;
                    end else begin
                        state_nxt = UPGRADE;
                    end
                end else if (i_gv) begin
                    ig_nxt    = i_gi;
                    state_nxt = IFETCH;
                end
            end
            UPGRADE: begin
                d_adv     = 1'b1;
                state_nxt = IDLE;
            end
            SNOOP: begin
                // Invalidate decision is frozen here so C2C/RAM_RD hold it
                // even if the requester changes ccwrite mid-transaction.
                inv_nxt   = ccwrite[req_q];
                state_nxt = dWEN[snp] ? C2C : RAM_RD;
            end
            C2C, RAM_RD, RAM_WR: begin
                if (ram_done) begin
                    d_adv     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            IFETCH: begin
                if (ram_done) begin
                    i_adv     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            req_q <= 1'b0;
            ig_q  <= 1'b0;
            inv_q <= 1'b0;
        end else begin
            state <= state_nxt;
            req_q <= req_nxt;
            ig_q  <= ig_nxt;
            inv_q <= inv_nxt;
        end
    end

    // Outputs decode from registered state only (strobes never see ramstate),
    // so an asynchronous reset returns every output to idle immediately.
    always_comb begin
        iwait       = '1;
        dwait       = '1;
        iload       = '0;
        dload       = '0;
        ramaddr     = '0;
        ramstore    = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ccwait      = '0;
        ccinv       = '0;
        ccsnoopaddr = '0;
        case (state)
            UPGRADE: begin
                ccwait[snp]      = 1'b1;
                ccinv[snp]       = 1'b1;
                ccsnoopaddr[snp] = daddr[req_q];
                dwait[req_q]     = 1'b0;
            end
            SNOOP: begin
                ccwait[snp]      = 1'b1;
                ccinv[snp]       = ccwrite[req_q];
                ccsnoopaddr[snp] = daddr[req_q];
            end
            C2C: begin
                ccwait[snp]      = 1'b1;
                ccinv[snp]       = inv_q;
                ccsnoopaddr[snp] = daddr[req_q];
                ramWEN           = 1'b1;
                ramaddr          = daddr[snp];
                ramstore         = dstore[snp];
                dload[req_q]     = dstore[snp];
                if (ram_done) begin
                    dwait[req_q] = 1'b0;
                    dwait[snp]   = 1'b0;
                end
            end
            RAM_RD: begin
                ccwait[snp]      = 1'b1;
                ccinv[snp]       = inv_q;
                ccsnoopaddr[snp] = daddr[req_q];
                ramREN           = 1'b1;
                ramaddr          = daddr[req_q];
                dload[req_q]     = ramload;
                if (ram_done) begin
                    dwait[req_q] = 1'b0;
                end
            end
            RAM_WR: begin
                ramWEN   = 1'b1;
                ramaddr  = daddr[req_q];
                ramstore = dstore[req_q];
                if (ram_done) begin
                    dwait[req_q] = 1'b0;
                end
            end
            IFETCH: begin
                ramREN      = 1'b1;
                ramaddr     = iaddr[ig_q];
                iload[ig_q] = ramload;
                if (ram_done) begin
                    iwait[ig_q] = 1'b0;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_coherence_bus_controller.sv
module tb_coherence_bus_controller;
    import coherence_bus_controller_pkg::*;

    logic             CLK = 1'b0;
    logic             RST;
    logic [1:0]       iREN, dREN, dWEN, ccwrite, cctrans;
    logic [1:0][31:0] iaddr, daddr, dstore;
    logic [31:0]      ramload = 32'h0;
    ramstate_t        ramstate = FREE;
    logic [1:0]       iwait, dwait, ccwait, ccinv;
    logic [1:0][31:0] iload, dload, ccsnoopaddr;
    logic [31:0]      ramaddr, ramstore;
    logic             ramREN, ramWEN;

    coherence_bus_controller #(.CPUS(2)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
        .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
        .ccwrite(ccwrite), .cctrans(cctrans),
        .ramload(ramload), .ramstate(ramstate),
        .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
        .ramaddr(ramaddr), .ramstore(ramstore), .ramREN(ramREN), .ramWEN(ramWEN),
        .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc++;

    // RAM model: after a strobe appears, 'lat' BUSY (or ERROR) cycles, then ACCESS.
    int          lat = 2;
    logic        use_err = 1'b0;
    logic [31:0] rdata = 32'h0;
    int          rcnt = 0;
    always @(posedge CLK) begin
        #1;
        if (ramREN || ramWEN) begin
            if (rcnt >= lat) begin
                ramstate = ACCESS;
                ramload  = rdata;
                rcnt     = 0;
            end else begin
                ramstate = use_err ? ERROR : BUSY;
                ramload  = 32'h0;
                rcnt++;
            end
        end else begin
            ramstate = FREE;
            ramload  = 32'h0;
            rcnt     = 0;
        end
    end

    typedef struct {
        string       name;
        logic [1:0]  iw, dw, cw, ci;
        logic        ren, wen;
        logic [31:0] addr, store;
        int          sidx;
        logic [31:0] saddr;
        int          lk, li;
        logic [31:0] lv;
        int          lat;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   t_issue = 0;

    function automatic exp_t mk(string nm, logic [1:0] iw, logic [1:0] dw,
                                logic [1:0] cw, logic [1:0] ci, logic ren, logic wen,
                                logic [31:0] addr, logic [31:0] store, int sidx,
                                logic [31:0] saddr, int lk, int li, logic [31:0] lv, int l);
        exp_t r;
        r.name = nm; r.iw = iw; r.dw = dw; r.cw = cw; r.ci = ci;
        r.ren = ren; r.wen = wen; r.addr = addr; r.store = store;
        r.sidx = sidx; r.saddr = saddr; r.lk = lk; r.li = li; r.lv = lv; r.lat = l;
        return r;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, expv);
        end
    endtask

    task automatic clear_inputs();
        iREN = '0; dREN = '0; dWEN = '0; ccwrite = '0; cctrans = '0;
        iaddr = '0; daddr = '0; dstore = '0;
    endtask

    task automatic issue_sync();
        @(posedge CLK);
        #1;
        t_issue = cyc;
    endtask

    task automatic drain(string nm, int budget);
        int k = 0;
        while (q.size() != 0 && k < budget) begin
            @(posedge CLK);
            k++;
        end
        #1;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL %s_timeout: %0d responses pending, expected 0", nm, q.size());
            q.delete();
        end
    endtask

    // SNOOP then RAM_RD completion for a clean read by CPU c.
    task automatic push_dread(string nm, int c, logic [31:0] a, logic [31:0] d);
        logic [1:0] sm, dm;
        int s;
        s  = 1 - c;
        sm = 2'b01 << s;
        dm = ~(2'b01 << c);
        q.push_back(mk({nm, "_snoop"}, 2'b11, 2'b11, sm, 2'b00, 1'b0, 1'b0,
                       32'h0, 32'h0, s, a, 0, 0, 32'h0, -1));
        q.push_back(mk({nm, "_done"}, 2'b11, dm, sm, 2'b00, 1'b1, 1'b0,
                       a, 32'h0, s, a, 2, c, d, -1));
    endtask

    initial begin
        RST = 1'b1;
        clear_inputs();
        fork
            forever begin
                @(negedge CLK);
                if (!RST && ((iwait != 2'b11) || (dwait != 2'b11) ||
                             (ccwait != 2'b00 && !ramREN && !ramWEN))) begin
                    if (q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_response: iwait=%b dwait=%b ccwait=%b ramREN=%b ramWEN=%b, expected none",
                                 iwait, dwait, ccwait, ramREN, ramWEN);
                    end else begin
                        e = q.pop_front();
                        chk({e.name, "_iwait"},  {30'h0, iwait},  {30'h0, e.iw});
                        chk({e.name, "_dwait"},  {30'h0, dwait},  {30'h0, e.dw});
                        chk({e.name, "_ccwait"}, {30'h0, ccwait}, {30'h0, e.cw});
                        chk({e.name, "_ccinv"},  {30'h0, ccinv},  {30'h0, e.ci});
                        chk({e.name, "_strobes"}, {30'h0, ramREN, ramWEN}, {30'h0, e.ren, e.wen});
                        if (e.ren || e.wen) chk({e.name, "_ramaddr"}, ramaddr, e.addr);
                        if (e.wen) chk({e.name, "_ramstore"}, ramstore, e.store);
                        if (e.sidx >= 0) chk({e.name, "_snoopaddr"}, ccsnoopaddr[e.sidx], e.saddr);
                        if (e.lk == 1) chk({e.name, "_iload"}, iload[e.li], e.lv);
                        if (e.lk == 2) chk({e.name, "_dload"}, dload[e.li], e.lv);
                        if (e.lat >= 0) chk({e.name, "_latency"}, cyc - t_issue, e.lat);
                    end
                end
            end
        join_none

        repeat (2) @(posedge CLK);
        #1;
        chk("rst_iwait",  {30'h0, iwait},  32'h3);
        chk("rst_dwait",  {30'h0, dwait},  32'h3);
        chk("rst_strobe", {30'h0, ramREN, ramWEN}, 32'h0);
        chk("rst_ccwait", {30'h0, ccwait, ccinv}, 32'h0);
        chk("rst_ramaddr", ramaddr, 32'h0);
        chk("rst_snoopaddr", ccsnoopaddr[0] | ccsnoopaddr[1], 32'h0);
        @(negedge CLK);
        RST = 1'b0;

        // icache fetch, 2 BUSY cycles
        issue_sync();
        lat = 2; rdata = 32'hDEADBEEF;
        iREN[0] = 1'b1; iaddr[0] = 32'h100;
        q.push_back(mk("ifetch", 2'b10, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0,
                       32'h100, 32'h0, -1, 32'h0, 1, 0, 32'hDEADBEEF, 3));
        drain("ifetch", 20);
        clear_inputs();

        // clean read miss by CPU1, one ERROR cycle treated as BUSY
        issue_sync();
        lat = 1; use_err = 1'b1; rdata = 32'hCAFE0040;
        dREN[1] = 1'b1; daddr[1] = 32'h40; cctrans[1] = 1'b1;
        q.push_back(mk("clean_snoop", 2'b11, 2'b11, 2'b01, 2'b00, 1'b0, 1'b0,
                       32'h0, 32'h0, 0, 32'h40, 0, 0, 32'h0, 1));
        q.push_back(mk("clean_done", 2'b11, 2'b01, 2'b01, 2'b00, 1'b1, 1'b0,
                       32'h40, 32'h0, 0, 32'h40, 2, 1, 32'hCAFE0040, 3));
        drain("clean", 20);
        clear_inputs();
        use_err = 1'b0;

        // dirty supply: CPU0 read-exclusive, CPU1 holds M copy
        issue_sync();
        lat = 1;
        dREN[0] = 1'b1; daddr[0] = 32'h80; ccwrite[0] = 1'b1; cctrans[0] = 1'b1;
        dWEN[1] = 1'b1; dstore[1] = 32'h1234; daddr[1] = 32'h80; cctrans[1] = 1'b1;
        q.push_back(mk("c2c_snoop", 2'b11, 2'b11, 2'b10, 2'b10, 1'b0, 1'b0,
                       32'h0, 32'h0, 1, 32'h80, 0, 0, 32'h0, -1));
        q.push_back(mk("c2c_done", 2'b11, 2'b00, 2'b10, 2'b10, 1'b0, 1'b1,
                       32'h80, 32'h1234, 1, 32'h80, 2, 0, 32'h1234, -1));
        drain("c2c", 20);
        clear_inputs();

        // S->M upgrade by CPU0
        issue_sync();
        cctrans[0] = 1'b1; ccwrite[0] = 1'b1; daddr[0] = 32'hC0;
        q.push_back(mk("upgrade", 2'b11, 2'b10, 2'b10, 2'b10, 1'b0, 1'b0,
                       32'h0, 32'h0, 1, 32'hC0, 0, 0, 32'h0, 1));
        drain("upgrade", 10);
        clear_inputs();

        // eviction write-back by CPU0 with immediate ACCESS
        issue_sync();
        lat = 0;
        dWEN[0] = 1'b1; daddr[0] = 32'h200; dstore[0] = 32'h55AA;
        q.push_back(mk("wb0", 2'b11, 2'b10, 2'b00, 2'b00, 1'b0, 1'b1,
                       32'h200, 32'h55AA, -1, 32'h0, 0, 0, 32'h0, -1));
        drain("wb0", 10);
        clear_inputs();

        // fairness: both dcaches read continuously, icache must wait
        issue_sync();
        lat = 1; rdata = 32'h0F0F0000;
        dREN = 2'b11; daddr[0] = 32'h300; daddr[1] = 32'h304;
        iREN[0] = 1'b1; iaddr[0] = 32'h400;
        for (int i = 0; i < 4; i++) begin
            push_dread("fair", i % 2, (i % 2 == 0) ? 32'h300 : 32'h304, 32'h0F0F0000);
        end
        drain("fair_d", 60);
        q.push_back(mk("fair_ifetch", 2'b10, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0,
                       32'h400, 32'h0, -1, 32'h0, 1, 0, 32'h0F0F0000, -1));
        dREN = 2'b00;
        drain("fair_i", 20);
        clear_inputs();

        // write-back by CPU1 leaves the dcache pointer on CPU1
        issue_sync();
        lat = 1;
        dWEN[1] = 1'b1; daddr[1] = 32'h240; dstore[1] = 32'h77;
        q.push_back(mk("wb1", 2'b11, 2'b01, 2'b00, 2'b00, 1'b0, 1'b1,
                       32'h240, 32'h77, -1, 32'h0, 0, 0, 32'h0, -1));
        drain("wb1", 10);
        clear_inputs();

        // reset during RAM_RD
        issue_sync();
        lat = 5;
        dREN[0] = 1'b1; daddr[0] = 32'h500;
        q.push_back(mk("rst_snoop", 2'b11, 2'b11, 2'b10, 2'b00, 1'b0, 1'b0,
                       32'h0, 32'h0, 1, 32'h500, 0, 0, 32'h0, -1));
        begin
            int k = 0;
            do begin
                @(negedge CLK);
                k++;
            end while (!ramREN && k < 20);
        end
        chk("midrd_ramREN", {31'h0, ramREN}, 32'h1);
        #2;
        RST = 1'b1;
        #1;
        chk("async_rst_strobe", {30'h0, ramREN, ramWEN}, 32'h0);
        chk("async_rst_iwait", {30'h0, iwait}, 32'h3);
        chk("async_rst_dwait", {30'h0, dwait}, 32'h3);
        chk("async_rst_ccwait", {30'h0, ccwait}, 32'h0);
        chk("async_rst_pending", q.size(), 32'h0);
        clear_inputs();
        @(posedge CLK);
        #1;
        chk("rst_edge_strobe", {30'h0, ramREN, ramWEN}, 32'h0);
        @(negedge CLK);
        RST = 1'b0;

        // pointer reset: CPU0 must win first even though CPU1 was next before reset
        issue_sync();
        lat = 1; rdata = 32'hA5A50600;
        dREN = 2'b11; daddr[0] = 32'h600; daddr[1] = 32'h604;
        push_dread("post_rst0", 0, 32'h600, 32'hA5A50600);
        push_dread("post_rst1", 1, 32'h604, 32'hA5A50600);
        drain("post_rst", 40);
        clear_inputs();

        // icache round-robin
        issue_sync();
        lat = 1; rdata = 32'h11112222;
        iREN = 2'b11; iaddr[0] = 32'h700; iaddr[1] = 32'h704;
        q.push_back(mk("irr0", 2'b10, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0,
                       32'h700, 32'h0, -1, 32'h0, 1, 0, 32'h11112222, -1));
        q.push_back(mk("irr1", 2'b01, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0,
                       32'h704, 32'h0, -1, 32'h0, 1, 1, 32'h11112222, -1));
        drain("irr", 30);
        clear_inputs();

        repeat (4) @(posedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
